// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, PC step and the fetch queue entry.
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0]    PC_STEP   = 32'd4;
    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc, instr} pairs with synchronous clear.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [XLEN-1:0]              wr_pc,
    input  logic [INSTR_W-1:0]           wr_instr,
    output logic [$clog2(DEPTH):0]       count,
    output logic [XLEN-1:0]              head_pc,
    output logic [INSTR_W-1:0]           head_instr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage is cleared on reset so the head outputs read zero before any fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '{pc: '0, instr: INSTR_NOP};
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{pc: wr_pc, instr: wr_instr};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_pc    = mem[rd_ptr].pc;
    assign head_instr = mem[rd_ptr].instr;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register addressing instruction RAM, redirect handling,
// and a small queue of fetched instructions toward decode.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic [XLEN-1:0]     addr_imem_o,
    input  logic [INSTR_W-1:0]  instr_imem_i,
    input  logic                halt_i,
    input  logic                redirect_valid_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    output logic                misalign_o,
    output logic                valid_dec_o,
    input  logic                ready_dec_i,
    output logic [INSTR_W-1:0]  instr_dec_o,
    output logic [XLEN-1:0]     pc_dec_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  pc;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign addr_imem_o = pc;
    assign valid_dec_o = (count != '0);

    // Redirect outranks both queue operations; a pop never frees space for a same-cycle push.
    assign push = !rst && !redirect_valid_i && !halt_i && (count < CNT_W'(DEPTH));
    assign pop  = valid_dec_o && ready_dec_i && !redirect_valid_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= redirect_valid_i && (|redirect_pc_i[1:0]);
            if (redirect_valid_i) begin
                pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
            end else if (push) begin
                pc <= pc + PC_STEP;
            end
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .clear      (redirect_valid_i),
        .push       (push),
        .pop        (pop),
        .wr_pc      (pc),
        .wr_instr   (instr_imem_i),
        .count      (count),
        .head_pc    (pc_dec_o),
        .head_instr (instr_dec_o)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch; the RAM model returns word k at byte address 4k.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_imem_o;
    logic [31:0] instr_imem_i;
    logic        halt_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        misalign_o;
    logic        valid_dec_o;
    logic        ready_dec_i;
    logic [31:0] instr_dec_o;
    logic [31:0] pc_dec_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign instr_imem_i = addr_imem_o >> 2;

    instr_fetch #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .addr_imem_o      (addr_imem_o),
        .instr_imem_i     (instr_imem_i),
        .halt_i           (halt_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .misalign_o       (misalign_o),
        .valid_dec_o      (valid_dec_o),
        .ready_dec_i      (ready_dec_i),
        .instr_dec_o      (instr_dec_o),
        .pc_dec_o         (pc_dec_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = pc >> 2;
        sb.push_back(e);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; halt_i = 1'b0; redirect_valid_i = 1'b0;
        redirect_pc_i = '0; ready_dec_i = 1'b0;
        tick; tick;
        checks++;
        if (addr_imem_o !== 32'h0 || valid_dec_o !== 1'b0 || instr_dec_o !== 32'h0 ||
            pc_dec_o !== 32'h0 || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: addr=%h valid=%b instr=%h pc=%h mis=%b, expected all zero",
                     addr_imem_o, valid_dec_o, instr_dec_o, pc_dec_o, misalign_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream;
        exp_t e;
        int   cycles = 0;
        int   stalls = 0;
        ready_dec_i = 1'b1;
        do_reset;
        checks++;
        if (valid_dec_o !== 1'b0 || addr_imem_o !== 32'h0) begin
            errors++;
            $display("FAIL stream_release: valid=%b addr=%h, expected valid=0 addr=00000000",
                     valid_dec_o, addr_imem_o);
        end
        tick;
        checks++;
        if (valid_dec_o !== 1'b1) begin
            errors++;
            $display("FAIL stream_first_valid: valid=%b, expected 1", valid_dec_o);
        end
        for (int k = 0; k < 8; k++) expect_pc(32'(k * 4));
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            if (valid_dec_o && ready_dec_i) begin
                e = sb.pop_front();
                checks++;
                if (pc_dec_o !== e.pc || instr_dec_o !== e.instr) begin
                    errors++;
                    $display("FAIL stream_head: got pc=%h instr=%h, expected pc=%h instr=%h",
                             pc_dec_o, instr_dec_o, e.pc, e.instr);
                end
            end else begin
                stalls++;
            end
            cycles++;
            tick;
        end
        checks++;
        if (sb.size() != 0 || stalls != 0 || cycles != 8) begin
            errors++;
            $display("FAIL stream_throughput: cycles=%0d stalls=%0d left=%0d, expected 8/0/0",
                     cycles, stalls, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        ready_dec_i = 1'b0;
        do_reset;
        repeat (5) tick;
        checks++;
        if (addr_imem_o !== 32'h8 || valid_dec_o !== 1'b1 || pc_dec_o !== 32'h0) begin
            errors++;
            $display("FAIL bp_hold: addr=%h valid=%b head=%h, expected addr=00000008 valid=1 head=00000000",
                     addr_imem_o, valid_dec_o, pc_dec_o);
        end
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
        ready_dec_i = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            if (valid_dec_o && ready_dec_i) begin
                e = sb.pop_front();
                checks++;
                if (pc_dec_o !== e.pc || instr_dec_o !== e.instr) begin
                    errors++;
                    $display("FAIL bp_order: got pc=%h instr=%h, expected pc=%h instr=%h",
                             pc_dec_o, instr_dec_o, e.pc, e.instr);
                end
            end
            tick;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL bp_timeout: %0d entries undelivered, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_redirect_full;
        exp_t e;
        ready_dec_i = 1'b0;
        do_reset;
        repeat (3) tick;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h0000_0100;
        tick;
        redirect_valid_i = 1'b0;
        checks++;
        if (valid_dec_o !== 1'b0 || addr_imem_o !== 32'h100 || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush: valid=%b addr=%h mis=%b, expected valid=0 addr=00000100 mis=0",
                     valid_dec_o, addr_imem_o, misalign_o);
        end
        tick;
        expect_pc(32'h100); expect_pc(32'h104); expect_pc(32'h108);
        checks++;
        if (valid_dec_o !== 1'b1 || pc_dec_o !== 32'h100) begin
            errors++;
            $display("FAIL redir_target: valid=%b head=%h, expected valid=1 head=00000100",
                     valid_dec_o, pc_dec_o);
        end
        ready_dec_i = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            if (valid_dec_o && ready_dec_i) begin
                e = sb.pop_front();
                checks++;
                if (pc_dec_o !== e.pc || instr_dec_o !== e.instr) begin
                    errors++;
                    $display("FAIL redir_order: got pc=%h instr=%h, expected pc=%h instr=%h",
                             pc_dec_o, instr_dec_o, e.pc, e.instr);
                end
            end
            tick;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL redir_timeout: %0d entries undelivered, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_misalign;
        ready_dec_i = 1'b0;
        tick;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h0000_0102;
        tick;
        redirect_valid_i = 1'b0;
        checks++;
        if (addr_imem_o !== 32'h100 || misalign_o !== 1'b1) begin
            errors++;
            $display("FAIL misalign_pulse: addr=%h mis=%b, expected addr=00000100 mis=1",
                     addr_imem_o, misalign_o);
        end
        tick;
        checks++;
        if (misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL misalign_width: mis=%b, expected 0", misalign_o);
        end
    endtask

    task automatic test_wrap;
        exp_t e;
        ready_dec_i      = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'hFFFF_FFFC;
        tick;
        redirect_valid_i = 1'b0;
        expect_pc(32'hFFFF_FFFC); expect_pc(32'h0000_0000); expect_pc(32'h0000_0004);
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            if (valid_dec_o && ready_dec_i) begin
                e = sb.pop_front();
                checks++;
                if (pc_dec_o !== e.pc || instr_dec_o !== e.instr) begin
                    errors++;
                    $display("FAIL wrap_order: got pc=%h instr=%h, expected pc=%h instr=%h",
                             pc_dec_o, instr_dec_o, e.pc, e.instr);
                end
            end
            tick;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL wrap_timeout: %0d entries undelivered, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_halt_and_reset;
        exp_t e;
        ready_dec_i = 1'b0;
        do_reset;
        repeat (3) tick;
        halt_i      = 1'b1;
        ready_dec_i = 1'b1;
        expect_pc(32'h0); expect_pc(32'h4);
        for (int c = 0; c < 10 && sb.size() != 0; c++) begin
            if (valid_dec_o && ready_dec_i) begin
                e = sb.pop_front();
                checks++;
                if (pc_dec_o !== e.pc || instr_dec_o !== e.instr) begin
                    errors++;
                    $display("FAIL halt_drain: got pc=%h instr=%h, expected pc=%h instr=%h",
                             pc_dec_o, instr_dec_o, e.pc, e.instr);
                end
            end
            tick;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL halt_timeout: %0d entries undelivered, expected 0", sb.size());
            sb.delete();
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (valid_dec_o !== 1'b0 || addr_imem_o !== 32'h8) begin
                errors++;
                $display("FAIL halt_idle: valid=%b addr=%h, expected valid=0 addr=00000008",
                         valid_dec_o, addr_imem_o);
            end
            tick;
        end
        halt_i      = 1'b0;
        ready_dec_i = 1'b0;
        tick; tick;
        checks++;
        if (valid_dec_o !== 1'b1 || pc_dec_o !== 32'h8) begin
            errors++;
            $display("FAIL midrst_pre: valid=%b head=%h, expected valid=1 head=00000008",
                     valid_dec_o, pc_dec_o);
        end
        rst              = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h0000_0106;
        tick;
        rst              = 1'b0;
        redirect_valid_i = 1'b0;
        checks++;
        if (addr_imem_o !== 32'h0 || valid_dec_o !== 1'b0 || instr_dec_o !== 32'h0 ||
            pc_dec_o !== 32'h0 || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: addr=%h valid=%b instr=%h pc=%h mis=%b, expected all zero",
                     addr_imem_o, valid_dec_o, instr_dec_o, pc_dec_o, misalign_o);
        end
        ready_dec_i = 1'b1;
        expect_pc(32'h0); expect_pc(32'h4);
        for (int c = 0; c < 10 && sb.size() != 0; c++) begin
            if (valid_dec_o && ready_dec_i) begin
                e = sb.pop_front();
                checks++;
                if (pc_dec_o !== e.pc || instr_dec_o !== e.instr) begin
                    errors++;
                    $display("FAIL midrst_restart: got pc=%h instr=%h, expected pc=%h instr=%h",
                             pc_dec_o, instr_dec_o, e.pc, e.instr);
                end
            end
            tick;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL midrst_timeout: %0d entries undelivered, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect_full;
        test_misalign;
        test_wrap;
        test_halt_and_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the instruction RAM and downstream consumer (decode). Holds the program counter, drives the word-aligned byte address into the instruction RAM, and captures the combinationally returned instruction. Buffers fetched {pc, instr} pairs in a small queue toward decode with a valid/ready handshake. Accepts redirects (branch/jump) from execute, and flushes the queue on redirect.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- DEPTH, 2: fetch queue entries; power of two, >= 2.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- addr_imem_o  out  32  byte address to instruction RAM; equals PC register; bits [1:0] always 0.
- instr_imem_i  in  32  instruction read from RAM for addr_imem_o; valid in the same cycle.
- halt_i  in  1  when high, no new fetch is pushed; PC holds; queue still drains.
- redirect_valid_i  in  1  one-cycle request to refetch from redirect_pc_i.
- redirect_pc_i  in  32  redirect target byte address.
- misalign_o  out  1  one-cycle registered pulse: last redirect target had nonzero bits [1:0].
- valid_dec_o  out  1  queue head holds an instruction for decode.
- ready_dec_i  in  1  decode accepts head this cycle.
- instr_dec_o  out  32  head instruction.
- pc_dec_o  out  32  byte PC of head instruction.

## Operation
- PC register drives addr_imem_o directly (no combinational path from inputs to addr_imem_o).
- Fetch (push) condition: !rst && !redirect_valid_i && !halt_i && count < DEPTH. On push: enqueue {pc, instr_imem_i}; pc <= pc + 4.
- PC increment wraps mod 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Pop condition: valid_dec_o && ready_dec_i && !redirect_valid_i. Push and pop in the same cycle: count unchanged. No push when count == DEPTH even if a pop occurs that cycle.
- valid_dec_o = (count != 0); instr_dec_o/pc_dec_o are head entry, registered storage only.
- Redirect (highest priority): pc <= {redirect_pc_i[31:2], 2'b00}; queue emptied (count <= 0, pointers reset); no push, no pop that cycle. misalign_o <= |redirect_pc_i[1:0] (otherwise 0 next cycle).
- halt_i with redirect: redirect still applied; halt only blocks pushes.
- ready_dec_i while valid_dec_o low: ignored.
- No write traffic to instruction RAM originates here.

## Timing
- Reset values: pc = RESET_PC (so addr_imem_o = RESET_PC), count = 0, valid_dec_o = 0, instr_dec_o = 0, pc_dec_o = 0, misalign_o = 0.
- rst asserted mid-operation: all state returns to reset values at that edge; in-flight queue contents discarded.
- Fetch-to-decode latency: 1 cycle (instruction addressed in cycle N visible at valid_dec_o in N+1).
- First cycle after reset release: addr_imem_o = RESET_PC; valid_dec_o high in the following cycle.
- Redirect asserted in cycle N: cycle N+1 valid_dec_o = 0, addr_imem_o = target; target instruction valid at decode in N+2.
- Sustained throughput with ready_dec_i held high: one instruction per cycle.
- Queue state machine implicit in count: EMPTY (0) -> PARTIAL -> FULL (DEPTH); FULL -> PARTIAL only via pop; any state -> EMPTY via redirect or rst.

## Structure
- Shared package cpu_pkg: XLEN = 32, INSTR_W = 32, PC_STEP = 32'd4, INSTR_NOP = 32'h0000_0000, fetch entry struct {pc, instr}.
- One sub-module: fetch_queue (DEPTH-entry circular FIFO, clear input, push/pop, count, head outputs). PC logic and redirect priority stay in instr_fetch.

## Test plan
- Reset, ready_dec_i = 1, RAM holds word k at address 4k: decode sees pc 0,4,8,... with matching instr, one per cycle, valid first high 1 cycle after rst falls.
- ready_dec_i = 0 for 5 cycles from reset: exactly 2 entries fetched (pc 0,4), addr_imem_o holds 8; release ready -> 0,4,8 delivered in order, none dropped or duplicated.
- Redirect to 32'h0000_0100 while queue full: next cycle valid_dec_o = 0, addr_imem_o = 0x100; following cycle head pc = 0x100; old entries never appear.
- Redirect to 32'h0000_0102: addr_imem_o = 0x100, misalign_o high exactly one cycle.
- Redirect to 32'hFFFF_FFFC with ready high: decode sees pc FFFF_FFFC then 0000_0000.
- halt_i high with 2 queued entries, ready high: both drain, then valid_dec_o = 0 and addr_imem_o constant; rst mid-stream -> all outputs at reset values next cycle.
